alu_seq_multiplier: RTL and testbench
=====================================

Name: alu_seq_multiplier

Overview:
Multi-cycle shift-add multiplier in the ALU. Its product feeds one data input of the ALU result multiplexer, alongside add, sub, slt and the logic ops.
- Accepts operands over a valid/ready handshake.
- Iterates one bit per cycle.
- Holds the result stable with out_valid until the downstream stage consumes it.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising-edge active.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands a/b (and is_signed) valid this cycle.
in_ready  output  1  block can accept operands this cycle.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
is_signed  input  1  signed multiply request; ignored unless ALU_MULT_SIGNED_EN.
out_valid  output  1  product valid and held.
out_ready  input  1  consumer accepts product.
product_lo  output  WIDTH  low half of product; routed to the result mux.
product_hi  output  WIDTH  high half of product.
overflow  output  1  product_hi is non-zero (unsigned) or not the sign-extension of product_lo (signed).

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; in_ready=1; out_valid=0; product_lo=0; product_hi=0; overflow=0; counter=0. Reset mid-operation aborts the operation silently; no partial result is ever presented.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a into mcand (zero-extended to 2*WIDTH), latch b into mplier, clear accumulator, counter=0, go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle: if mplier[0], acc = acc + mcand (2*WIDTH-bit add, carry discarded). Then mcand <<= 1, mplier >>= 1, counter++.
  - When counter reaches WIDTH-1, the final add completes and the state goes to DONE.
  - BUSY lasts exactly WIDTH cycles.
- DONE:
  - out_valid=1; product_lo/hi/overflow registered and held stable while out_ready=0.
  - On out_valid&out_ready: go to IDLE; out_valid drops next cycle.
- Latency: operand-accept edge to out_valid high = WIDTH+1 clock edges.
- Throughput: one product per WIDTH+2 cycles minimum. No overlap: in_ready is 0 in BUSY and DONE.
- Zero operand: full WIDTH iterations are still taken; no early termination, so latency is fixed.
- Edge cases:
  - Max operands: a=b=2^WIDTH-1 gives product_hi=2^WIDTH-2, product_lo=1, overflow=1.
  - in_valid asserted during BUSY/DONE: ignored, not latched; the source must hold it until in_ready.
  - out_ready high before DONE: no effect.
- Outputs product_lo/hi keep the last result after returning to IDLE until the next DONE.

Optional Feature:
ALU_MULT_SIGNED_EN.
- Defined:
  - When is_signed=1 at accept, operands are converted to magnitudes and the result sign (a[WIDTH-1]^b[WIDTH-1]) is latched.
  - On the BUSY-to-DONE transition the product is two's-complement negated if the sign is 1; negation happens in the same edge, so latency is unchanged.
  - overflow uses the signed rule.
- Undefined:
  - is_signed is unused (tie-off warning acceptable); all multiplies are unsigned.
  - No sign register or negation logic is synthesized.

Decomposition:
- Shared ALU defines header (alongside the ALU op-code defines): state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2; default WIDTH; ALU op code selecting the multiplier result at the mux.
- One sub-module: alu_mult_datapath, covering the acc/mcand/mplier registers, adder and shifters, with load/step/negate controls.
- The top holds the FSM, counter and handshake.

Test Plan:
- Reset: pull rst_n low mid-BUSY (a=7, b=9) -> out_valid=0, in_ready=1, products 0 immediately without a clock; after release, no stale DONE appears.
- Basic: a=6, b=7, out_ready=1 -> out_valid rises exactly 33 edges after accept; product_lo=42, product_hi=0, overflow=0.
- Max: a=b=32'hFFFFFFFF -> product_hi=32'hFFFFFFFE, product_lo=32'h00000001, overflow=1.
- Backpressure: a=3, b=5, out_ready=0 for 10 cycles after DONE -> product_lo=15 held, out_valid held; in_ready=0 throughout; a new in_valid is not accepted until the cycle after the out_ready handshake.
- Zero/back-to-back: a=0, b=12345, then a=1, b=32'h80000000 -> 0, then product_lo=32'h80000000; each takes the full 33-cycle latency.
- With ALU_MULT_SIGNED_EN: is_signed=1, a=-3, b=5 -> {hi,lo}=64'hFFFFFFFF_FFFFFFF1, overflow=0. Same operands with is_signed=0 -> unsigned product 32'h00000004_FFFFFFF1, overflow=1.

Source files
------------

// File: rtl/alu_seq_multiplier_pkg.sv
// Shared ALU multiplier definitions: FSM state encodings, default sizes, result-mux op code.
// Optional signed multiply is enabled by defining ALU_MULT_SIGNED_EN.
package alu_seq_multiplier_pkg;

    localparam int unsigned ALU_MULT_WIDTH = 32;
    localparam int unsigned ALU_MULT_CNT_W = 6;

    // ALU result-mux select codes; MUL picks the multiplier's product_lo
    localparam int unsigned ALU_OP_W = 4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLT = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XOR = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_OP_MUL = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/alu_mult_datapath.sv
// Shift-add multiplier datapath: accumulator, shifting multiplicand/multiplier, result registers.
// With ALU_MULT_SIGNED_EN, operands are loaded as magnitudes and the result is negated on capture.
module alu_mult_datapath
    import alu_seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_MULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             finish_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
`ifdef ALU_MULT_SIGNED_EN
    input  logic             is_signed_i,
`endif
    output logic [WIDTH-1:0] product_lo_o,
    output logic [WIDTH-1:0] product_hi_o,
    output logic             overflow_o
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    product_q, product_d;
    logic             overflow_q, overflow_d;
    logic [PW-1:0]    sum_c, result_c;
    logic [WIDTH-1:0] a_load_c, b_load_c;
    logic             ovf_c;

`ifdef ALU_MULT_SIGNED_EN
    logic sign_q, sign_d;
    logic signed_q, signed_d;

    // Magnitude conversion on load, sign-corrected result and signed/unsigned overflow rule
    always_comb begin
        a_load_c = a_i;
        b_load_c = b_i;
        sign_d   = sign_q;
        signed_d = signed_q;
        if (is_signed_i && a_i[WIDTH-1]) a_load_c = ~a_i + WIDTH'(1);
        if (is_signed_i && b_i[WIDTH-1]) b_load_c = ~b_i + WIDTH'(1);
        if (load_i) begin
            sign_d   = is_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            signed_d = is_signed_i;
        end
        result_c = sign_q ? (~sum_c + PW'(1)) : sum_c;
        if (signed_q) ovf_c = (result_c[PW-1:WIDTH] != {WIDTH{result_c[WIDTH-1]}});
        else          ovf_c = (result_c[PW-1:WIDTH] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q   <= 1'b0;
            signed_q <= 1'b0;
        end else begin
            sign_q   <= sign_d;
            signed_q <= signed_d;
        end
    end
`else
    always_comb begin
        a_load_c = a_i;
        b_load_c = b_i;
        result_c = sum_c;
        ovf_c    = (result_c[PW-1:WIDTH] != '0);
    end
`endif

    assign sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Load / iterate / capture sequencing of the datapath registers
    always_comb begin
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        product_d  = product_q;
        overflow_d = overflow_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_load_c};
            mplier_d = b_load_c;
        end else if (step_i) begin
            acc_d    = sum_c;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
        if (finish_i) begin
            product_d  = result_c;
            overflow_d = ovf_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
        end
    end

    assign product_lo_o = product_q[WIDTH-1:0];
    assign product_hi_o = product_q[PW-1:WIDTH];
    assign overflow_o   = overflow_q;

endmodule

// File: rtl/alu_seq_multiplier.sv
// Sequential shift-add multiplier top: IDLE/BUSY/DONE FSM, iteration counter, valid/ready handshakes.
// Define ALU_MULT_SIGNED_EN to honour is_signed; otherwise every multiply is unsigned.
module alu_seq_multiplier
    import alu_seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_MULT_WIDTH,
    parameter int unsigned CNT_W = ALU_MULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi,
    output logic             overflow
);

    mult_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, out_valid_q;
    logic             accept_c, last_c;
    logic             load_c, step_c, finish_c;

    assign accept_c = in_valid & in_ready_q;
    assign last_c   = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept_c) state_d = BUSY;
            BUSY:    if (last_c) state_d = DONE;
            DONE:    if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath controls and counter update; the final add and result capture share the last BUSY edge
    always_comb begin
        load_c   = 1'b0;
        step_c   = 1'b0;
        finish_c = 1'b0;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    load_c = 1'b1;
                    cnt_d  = '0;
                end
            end
            BUSY: begin
                step_c   = 1'b1;
                finish_c = last_c;
                cnt_d    = cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

`ifndef ALU_MULT_SIGNED_EN
    logic unused_is_signed;
    assign unused_is_signed = is_signed;
`endif

    alu_mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (load_c),
        .step_i       (step_c),
        .finish_i     (finish_c),
        .a_i          (a),
        .b_i          (b),
`ifdef ALU_MULT_SIGNED_EN
        .is_signed_i  (is_signed),
`endif
        .product_lo_o (product_lo),
        .product_hi_o (product_hi),
        .overflow_o   (overflow)
    );

endmodule

// File: tb/tb_alu_seq_multiplier.sv
// Directed bench for alu_seq_multiplier; signed-mode expectations follow ALU_MULT_SIGNED_EN.
`timescale 1ns/1ps
module tb_alu_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product_lo;
    logic [31:0] product_hi;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    alu_seq_multiplier #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .is_signed  (is_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .product_lo (product_lo),
        .product_hi (product_hi),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept_op(input logic [31:0] ta, input logic [31:0] tbv, input logic ts);
        a         = ta;
        b         = tbv;
        is_signed = ts;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    // Edges counted from the accept edge (which counts as 1) until out_valid is seen
    task automatic wait_done(output int edges);
        edges = 1;
        while (!out_valid && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
        check({tag, " in_ready back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        logic seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;

        #12;
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset product", {product_hi, product_lo}, 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic 6*7 with out_ready held high from the start
        out_ready = 1'b1;
        accept_op(32'd6, 32'd7, 1'b0);
        check("basic in_ready busy", 64'(in_ready), 64'd0);
        wait_done(lat);
        check("basic latency", 64'(lat), 64'd33);
        check("basic product", {product_hi, product_lo}, 64'd42);
        check("basic overflow", 64'(overflow), 64'd0);
        consume("basic");
        check("basic held in idle", 64'(product_lo), 64'd42);

        // Reset mid-BUSY aborts 7*9
        accept_op(32'd7, 32'd9, 1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst in_ready", 64'(in_ready), 64'd1);
        check("midrst product", {product_hi, product_lo}, 64'd0);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst no stale done", 64'(seen), 64'd0);
        check("midrst idle in_ready", 64'(in_ready), 64'd1);

        // Maximum operands
        accept_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(lat);
        check("max latency", 64'(lat), 64'd33);
        check("max product", {product_hi, product_lo}, 64'hFFFF_FFFE_0000_0001);
        check("max overflow", 64'(overflow), 64'd1);
        consume("max");

        // Backpressure 3*5, with a pending new request during DONE
        out_ready = 1'b0;
        accept_op(32'd3, 32'd5, 1'b0);
        wait_done(lat);
        check("bp latency", 64'(lat), 64'd33);
        a        = 32'd2;
        b        = 32'd4;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp out_valid held", 64'(out_valid), 64'd1);
            check("bp in_ready low", 64'(in_ready), 64'd0);
            check("bp product held", {product_hi, product_lo}, 64'd15);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp handshake out_valid", 64'(out_valid), 64'd0);
        check("bp handshake in_ready", 64'(in_ready), 64'd1);
        check("bp product after hs", 64'(product_lo), 64'd15);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp next accepted", 64'(in_ready), 64'd0);
        wait_done(lat);
        check("bp next latency", 64'(lat), 64'd33);
        check("bp next product", {product_hi, product_lo}, 64'd8);
        consume("bp next");

        // Zero operand then back-to-back
        accept_op(32'd0, 32'd12345, 1'b0);
        wait_done(lat);
        check("zero latency", 64'(lat), 64'd33);
        check("zero product", {product_hi, product_lo}, 64'd0);
        check("zero overflow", 64'(overflow), 64'd0);
        consume("zero");
        accept_op(32'd1, 32'h8000_0000, 1'b0);
        wait_done(lat);
        check("b2b latency", 64'(lat), 64'd33);
        check("b2b product", {product_hi, product_lo}, 64'h0000_0000_8000_0000);
        check("b2b overflow", 64'(overflow), 64'd0);
        consume("b2b");

        // -3 * 5 with is_signed requested
        accept_op(32'hFFFF_FFFD, 32'd5, 1'b1);
        wait_done(lat);
        check("sreq latency", 64'(lat), 64'd33);
`ifdef ALU_MULT_SIGNED_EN
        check("sreq product", {product_hi, product_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        check("sreq overflow", 64'(overflow), 64'd0);
`else
        check("sreq product", {product_hi, product_lo}, 64'h0000_0004_FFFF_FFF1);
        check("sreq overflow", 64'(overflow), 64'd1);
`endif
        consume("sreq");

        // Same operands unsigned
        accept_op(32'hFFFF_FFFD, 32'd5, 1'b0);
        wait_done(lat);
        check("ureq latency", 64'(lat), 64'd33);
        check("ureq product", {product_hi, product_lo}, 64'h0000_0004_FFFF_FFF1);
        check("ureq overflow", 64'(overflow), 64'd1);
        consume("ureq");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
